// File: rtl/msk_rcon_pkg.sv
// Shared types and constants for the masked AES round-constant sequencer.
// Optional feature macro: MSK_RCON_INV_EN (see msk_rcon_seq.sv).
package msk_rcon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int         NROUNDS    = 10;
  localparam logic [7:0] RCON_FIRST = 8'h01;
  localparam logic [7:0] RCON_LAST  = 8'h36;
  localparam logic [7:0] AES_POLY   = 8'h1B;

  // Multiply by x in GF(2^8) modulo the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? AES_POLY : 8'h00);
  endfunction

  // Divide by x in GF(2^8); undoes xtime.
  function automatic logic [7:0] inv_xtime(input logic [7:0] r);
    return r[0] ? (((r ^ AES_POLY) >> 1) | 8'h80) : (r >> 1);
  endfunction

endpackage

// File: rtl/MSKcst.sv
// Public constant to d-share encoding: share 0 carries the bit, other shares
// are zero. Bit j share i lands at index j*d+i.
module MSKcst #(
  parameter int d     = 2,
  parameter int count = 1
) (
  input  logic [count-1:0]   cst,
  output logic [count*d-1:0] out
);

  genvar j, s;
  generate
    for (j = 0; j < count; j++) begin : g_bit
      for (s = 0; s < d; s++) begin : g_shr
        if (s == 0) begin : g_s0
          assign out[j*d+s] = cst[j];
        end else begin : g_sn
          assign out[j*d+s] = 1'b0;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/msk_rcon_seq.sv
// Masked AES round-constant sequencer: on start, streams the 10 round
// constants through a valid/ready port as a d-share sharing, then pulses done.
// Define MSK_RCON_INV_EN to add the inv input, which runs the sequence in
// reverse order (36 down to 01) for decryption key schedules.
`ifndef DEFAULTSHARES
`define DEFAULTSHARES 2
`endif

module msk_rcon_seq
  import msk_rcon_pkg::*;
#(
  parameter int d = `DEFAULTSHARES
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
`ifdef MSK_RCON_INV_EN
  input  logic           inv,
`endif
  input  logic           clear,
  output logic           busy,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [3:0]     out_round,
  output logic [8*d-1:0] rcon_sh,
  output logic           done
);

  localparam logic [3:0] LAST_RND = 4'(NROUNDS);

  state_e     state;
  logic [7:0] rcon;
  logic [7:0] rcon_nxt;
  logic [7:0] rcon_pub;
  logic [3:0] rnd;
  logic       run;
  logic       fire;

  assign run  = (state == ST_RUN);
  assign fire = run & out_ready;

`ifdef MSK_RCON_INV_EN
  logic inv_q;

  // Direction latched at start selects forward or inverse stepping.
  always_comb begin
    rcon_nxt = inv_q ? inv_xtime(rcon) : xtime(rcon);
  end
`else
  // Forward-only stepping.
  always_comb begin
    rcon_nxt = xtime(rcon);
  end
`endif

  // Sequencer FSM, constant and round counter; clear overrides everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      rcon  <= RCON_FIRST;
      rnd   <= 4'd0;
`ifdef MSK_RCON_INV_EN
      inv_q <= 1'b0;
`endif
    end else if (clear) begin
      state <= ST_IDLE;
      rnd   <= 4'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_RUN;
            rnd   <= 4'd1;
`ifdef MSK_RCON_INV_EN
            inv_q <= inv;
            rcon  <= inv ? RCON_LAST : RCON_FIRST;
`else
            rcon  <= RCON_FIRST;
`endif
          end
        end
        ST_RUN: begin
          if (fire) begin
            if (rnd == LAST_RND) begin
              state <= ST_DONE;
              rnd   <= 4'd0;
            end else begin
              rcon <= rcon_nxt;
              rnd  <= rnd + 4'd1;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Outputs are gated by RUN so IDLE/DONE (and reset) present all zeros.
  always_comb begin
    busy      = run;
    out_valid = run;
    out_round = run ? rnd : 4'd0;
    rcon_pub  = run ? rcon : 8'h00;
    done      = (state == ST_DONE);
  end

  MSKcst #(
    .d     (d),
    .count (8)
  ) u_enc (
    .cst (rcon_pub),
    .out (rcon_sh)
  );

endmodule

// File: tb/tb_msk_rcon_seq.sv
// Directed bench for msk_rcon_seq: full forward run, back-pressure, clear,
// asynchronous reset mid-run and (with MSK_RCON_INV_EN) the inverse order.
module tb_msk_rcon_seq;

`ifdef MSK_RCON_INV_EN
  localparam int D = 3;
`else
  localparam int D = 2;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           clear = 1'b0;
  logic           out_ready = 1'b0;
`ifdef MSK_RCON_INV_EN
  logic           inv = 1'b0;
`endif
  logic           busy;
  logic           out_valid;
  logic [3:0]     out_round;
  logic [8*D-1:0] rcon_sh;
  logic           done;

  int errs = 0;
  int checks = 0;

  logic [7:0] fwd [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                           8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
`ifdef MSK_RCON_INV_EN
  logic [7:0] rev [10] = '{8'h36, 8'h1B, 8'h80, 8'h40, 8'h20,
                           8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
`endif

  msk_rcon_seq #(.d(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
`ifdef MSK_RCON_INV_EN
    .inv       (inv),
`endif
    .clear     (clear),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_round (out_round),
    .rcon_sh   (rcon_sh),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Sharing (r,0,..,0): bit j of r at index j*D.
  function automatic logic [31:0] enc(input logic [7:0] r);
    logic [31:0] v;
    v = '0;
    for (int j = 0; j < 8; j++) v[j*D] = r[j];
    return v;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " busy"},  32'(busy), 32'd0);
    chk({tag, " valid"}, 32'(out_valid), 32'd0);
    chk({tag, " round"}, 32'(out_round), 32'd0);
    chk({tag, " sh"},    32'(rcon_sh), 32'd0);
    chk({tag, " done"},  32'(done), 32'd0);
  endtask

  task automatic chk_run(input string tag, input int rnd, input logic [7:0] r);
    chk({tag, " valid"}, 32'(out_valid), 32'd1);
    chk({tag, " busy"},  32'(busy), 32'd1);
    chk({tag, " round"}, 32'(out_round), 32'(rnd));
    chk({tag, " sh"},    32'(rcon_sh), enc(r));
    chk({tag, " done"},  32'(done), 32'd0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    // reset state
    #12;
    chk_idle("rst");
    tick();
    rst_n = 1'b1;
    tick();
    chk_idle("idle");

    // full forward run, consumer always ready
    start = 1'b1;
    out_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      chk_run($sformatf("fwd%0d", k + 1), k + 1, fwd[k]);
      chk($sformatf("fwd%0d upper shares", k + 1), 32'(rcon_sh) & ~enc(8'hFF), 32'd0);
      tick();
    end
    chk("done pulse", 32'(done), 32'd1);
    chk("done valid", 32'(out_valid), 32'd0);
    chk("done round", 32'(out_round), 32'd0);
    chk("done busy",  32'(busy), 32'd0);
    tick();
    chk_idle("post done");

    // back-pressure at round 3
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk_run($sformatf("stall%0d", i), 3, 8'h04);
      tick();
    end
    chk_run("stall end", 3, 8'h04);
    out_ready = 1'b1;
    tick();
    chk_run("after stall", 4, 8'h08);

    // start during a fire in RUN is ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_run("start in run", 5, 8'h10);
    tick();
    chk_run("round6", 6, 8'h20);

    // clear together with start at round 6
    clear = 1'b1;
    start = 1'b1;
    tick();
    clear = 1'b0;
    start = 1'b0;
    chk_idle("clear");
    tick();
    chk_idle("clear idle");
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_run("restart", 1, 8'h01);

    // asynchronous reset mid round 8
    repeat (7) tick();
    chk_run("round8", 8, 8'h80);
    #2 rst_n = 1'b0;
    #1 chk_idle("async rst");
    tick();
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      tick();
      if (done || busy || out_valid) seen++;
    end
    chk("no activity after rst", 32'(seen), 32'd0);

`ifdef MSK_RCON_INV_EN
    // inverse order, d=3
    inv = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    inv = 1'b0;
    for (int k = 0; k < 10; k++) begin
      chk_run($sformatf("inv%0d", k + 1), k + 1, rev[k]);
      tick();
    end
    chk("inv done pulse", 32'(done), 32'd1);
    tick();
    chk_idle("inv post done");
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/msk_rcon_seq.md
MSK_RCON_SEQ -- requirements
Module: msk_rcon_seq

Interface
REQ-001 SHALL have parameter d, default `DEFAULTSHARES (2 if undefined), number of shares.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  one-cycle request to begin a 10-round constant sequence.
REQ-005 SHALL have port clear  input  1  synchronous abort of the sequence in progress.
REQ-006 SHALL have port busy  output  1  high while the sequence is in RUN.
REQ-007 SHALL have port out_valid  output  1  masked round constant available.
REQ-008 SHALL have port out_ready  input  1  consumer accepts the constant.
REQ-009 SHALL have port out_round  output  4  round index 1..10 of the presented constant.
REQ-010 SHALL have port rcon_sh  output  8*d  masked constant; bit j share i at index j*d+i.
REQ-011 SHALL have port done  output  1  one-cycle pulse after the 10th transfer.

Function
REQ-012 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE.
REQ-013 IDLE: start=1 and clear=0 -> RUN next cycle; otherwise hold.
REQ-014 RUN: out_valid=1, busy=1; first constant is valid in the cycle after start (latency 1).
REQ-015 Fire = out_valid & out_ready; rcon_sh and out_round SHALL stay stable while out_valid=1 and out_ready=0.
REQ-016 On fire with out_round<10: rcon <= xtime(rcon) (shift left; if bit7 set, XOR 8'h1B), out_round <= out_round+1.
REQ-017 On fire with out_round=10: go to DONE; done=1 for exactly that one cycle; then IDLE.
REQ-018 Constant sequence SHALL be 01,02,04,08,10,20,40,80,1B,36.
REQ-019 rcon_sh SHALL be the public rcon as sharing (rcon,0,...,0): share 0 carries the bit, shares 1..d-1 are zero.
REQ-020 start SHALL be ignored outside IDLE, including in the same cycle as a fire.
REQ-021 clear SHALL force IDLE next cycle from any state; clear beats start and fire; no done pulse on abort.
REQ-022 In IDLE and DONE: out_valid=0, busy=0, out_round=0, rcon_sh all zero.

Reset
REQ-023 rst_n=0 SHALL immediately force IDLE, rcon=8'h01, out_round=0, all outputs 0, independent of clk.
REQ-024 Reset mid-RUN SHALL discard the sequence; after release the block waits for a new start.

Configuration
REQ-025 Macro MSK_RCON_INV_EN: when defined, SHALL add input inv (1 bit, sampled with start).
REQ-026 With inv=1: sequence 36,1B,80,...,01, next = inverse xtime (bit0 set: ((r^1B)>>1)|80, else r>>1); out_round still counts 1..10.
REQ-027 Without MSK_RCON_INV_EN: no inv port; forward order only; no inverse logic synthesized.

Structure
REQ-028 Package msk_rcon_pkg SHALL hold state enum, NROUNDS=10, RCON_FIRST=8'h01, RCON_LAST=8'h36, AES_POLY=8'h1B.
REQ-029 Encoding to shares SHALL be one instance of the codebase constant-masking module MSKcst (d=d, count=8); no other sub-module.

Verification
REQ-030 d=2, start, out_ready=1 constantly -> 10 consecutive transfers 01..36, rcon_sh[1]=rcon_sh[3]=...=0, done pulse 1 cycle after 10th fire.
REQ-031 out_ready held 0 for 5 cycles at round 3 -> rcon_sh=04-sharing and out_round=3 stable, then round 4 = 08.
REQ-032 clear asserted at round 6 together with start -> IDLE next cycle, no done, next start restarts at 01.
REQ-033 rst_n pulsed low mid-cycle in round 8 -> outputs 0 immediately, no done after release.
REQ-034 MSK_RCON_INV_EN defined, inv=1, d=3 -> sequence 36,1B,80,40,...,01; shares 1,2 zero throughout.
